// File: rtl/cfg_pkg.sv
// cfg_pkg: constants and types shared by the Si5340 config-link responder
package cfg_pkg;
    localparam logic [6:0] SLAVE_ADDR = 7'b111_0100;
    localparam logic [7:0] PAGE_REG   = 8'h01;
    typedef enum logic {RW_WRITE = 1'b0, RW_READ = 1'b1} rw_t;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } i2c_slv_state_t;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes SCL/SDA and flags SCL edges plus START/STOP
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic scl_h, sda_h, scl_s;
    // synchronizer chains plus one history flop; idle bus level is high
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_h <= 1'b1;
            sda_h <= 1'b1;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], scl_i};
            sda_q <= {sda_q[SYNC_STAGES-2:0], sda_i};
            scl_h <= scl_q[SYNC_STAGES-1];
            sda_h <= sda_q[SYNC_STAGES-1];
        end
    end
    assign scl_s    = scl_q[SYNC_STAGES-1];
    assign sda      = sda_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign start    = scl_s & scl_h & sda_h & ~sda;
    assign stop     = scl_s & scl_h & ~sda_h & sda;
endmodule

// File: rtl/i2c_cfg_responder.sv
// i2c_cfg_responder: I2C responder modelling the Si5340 page/register config interface
module i2c_cfg_responder import cfg_pkg::*; #(
    parameter logic [6:0] SLAVE_ADDR  = cfg_pkg::SLAVE_ADDR,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] PAGE_REG    = cfg_pkg::PAGE_REG
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o,
    output logic        wr_en_o,
    output logic [15:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        rd_en_o,
    output logic [15:0] rd_addr_o,
    input  logic [7:0]  rd_data_i,
    output logic        busy_o
);
    i2c_slv_state_t state, state_n;
    rw_t            rw, rw_n;
    logic [3:0]     cnt, cnt_n;
    logic [7:0]     sh, sh_n, page, page_n, regp, regp_n, tx, tx_n, rx;
    logic           ackd, ackd_n, oe_n, wr_en_n, rd_en_n, busy_n, rd_dly;
    logic [15:0]    wr_addr_n, rd_addr_n;
    logic [7:0]     wr_data_n;
    logic           sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i(clk_i), .rstn_i(rstn_i), .scl_i(scl_i), .sda_i(sda_i),
        .sda(sda_s), .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
    );

    assign rx = {sh[6:0], sda_s};

    // state and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            rw        <= RW_WRITE;
            cnt       <= '0;
            sh        <= '0;
            page      <= '0;
            regp      <= '0;
            tx        <= '0;
            ackd      <= 1'b0;
            sda_oe_o  <= 1'b0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
            rd_dly    <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state     <= state_n;
            rw        <= rw_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            page      <= page_n;
            regp      <= regp_n;
            tx        <= tx_n;
            ackd      <= ackd_n;
            sda_oe_o  <= oe_n;
            wr_en_o   <= wr_en_n;
            wr_addr_o <= wr_addr_n;
            wr_data_o <= wr_data_n;
            rd_en_o   <= rd_en_n;
            rd_addr_o <= rd_addr_n;
            rd_dly    <= rd_en_o;
            busy_o    <= busy_n;
        end
    end

    // bus protocol: START/STOP override everything, then per-state bit handling
    always_comb begin
        state_n   = state;
        rw_n      = rw;
        cnt_n     = cnt;
        sh_n      = sh;
        page_n    = page;
        regp_n    = regp;
        tx_n      = rd_dly ? rd_data_i : tx;
        ackd_n    = ackd;
        oe_n      = sda_oe_o;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr_o;
        wr_data_n = wr_data_o;
        rd_en_n   = 1'b0;
        rd_addr_n = rd_addr_o;
        busy_n    = busy_o;
        if (stop || start) begin
            state_n = stop ? IDLE : ADDR;
            cnt_n   = '0;
            ackd_n  = 1'b0;
            oe_n    = 1'b0;
            busy_n  = start;
        end else begin
            case (state)
                ADDR, REG, WDATA: if (scl_rise) begin
                    sh_n  = rx;
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_n = '0;
                        if (state == ADDR) begin
                            rw_n    = rw_t'(rx[0]);
                            state_n = (rx[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                        end else if (state == REG) begin
                            regp_n  = rx;
                            state_n = REG_ACK;
                        end else begin
                            wr_en_n   = 1'b1;
                            wr_addr_n = {page, regp};
                            wr_data_n = rx;
                            page_n    = (regp == PAGE_REG) ? rx : page;
                            regp_n    = regp + 8'd1;
                            state_n   = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK, REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        ackd_n  = ~ackd;
                        oe_n    = ~ackd;
                        state_n = ackd ? ((state == ADDR_ACK) ? REG : WDATA) : state;
                    end
                    if (scl_rise && ackd && state == ADDR_ACK && rw == RW_READ) begin
                        rd_en_n   = 1'b1;
                        rd_addr_n = {page, regp};
                        ackd_n    = 1'b0;
                        cnt_n     = '0;
                        state_n   = RDATA;
                    end
                end
                RDATA: if (scl_fall) begin
                    oe_n    = (cnt == 4'd8) ? 1'b0 : ~tx[7];
                    tx_n    = {tx[6:0], 1'b0};
                    cnt_n   = (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
                    state_n = (cnt == 4'd8) ? RDATA_ACK : RDATA;
                end
                RDATA_ACK: if (scl_rise) begin
                    state_n   = sda_s ? IGNORE : RDATA;
                    regp_n    = sda_s ? regp : regp + 8'd1;
                    rd_en_n   = ~sda_s;
                    rd_addr_n = sda_s ? rd_addr_o : {page, regp + 8'd1};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_cfg_responder.sv
// tb_i2c_cfg_responder: bit-banged I2C master with scoreboard for strobes and read data
module tb_i2c_cfg_responder;
    import cfg_pkg::*;
    localparam int Q = 6;

    logic clk = 1'b0, rstn = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic sda_oe, wr_en, rd_en, busy;
    logic [15:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data = 8'h00;
    wire sda_line = sda_m & ~sda_oe;

    always #4 clk = ~clk;

    i2c_cfg_responder dut (
        .clk_i(clk), .rstn_i(rstn), .scl_i(scl_m), .sda_i(sda_line),
        .sda_oe_o(sda_oe), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data), .busy_o(busy)
    );

    int ncmp = 0, nerr = 0;
    logic [7:0]  rmem [65536];
    logic [7:0]  m_page = 8'h00, m_reg = 8'h00;
    logic [23:0] wq [$];
    logic [15:0] rq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic qw(input int n = 1);
        repeat (n * Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b0; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b1; qw();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; qw();
        scl_m = 1'b1; qw(2);
        scl_m = 1'b0; qw();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        b = sda_line; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic nack);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        chk("ack", {31'd0, a}, {31'd0, nack});
    endtask

    task automatic read_byte(output logic [7:0] b);
        for (int i = 7; i >= 0; i--) read_bit(b[i]);
    endtask

    task automatic wr_txn(input logic [6:0] addr, input logic [7:0] r, input int n, input logic [23:0] d);
        logic hit;
        logic [7:0] v;
        hit = (addr == SLAVE_ADDR);
        i2c_start();
        write_byte({addr, 1'b0}, ~hit);
        write_byte(r, ~hit);
        if (hit) m_reg = r;
        for (int i = 0; i < n; i++) begin
            v = d[23 - 8*i -: 8];
            if (hit) begin
                wq.push_back({m_page, m_reg, v});
                if (m_reg == 8'h01) m_page = v;
                m_reg = m_reg + 8'd1;
            end
            write_byte(v, ~hit);
        end
        i2c_stop();
        qw();
    endtask

    task automatic rd_txn(input logic [7:0] r, input int n);
        logic [7:0] b;
        i2c_start();
        write_byte({SLAVE_ADDR, 1'b0}, 1'b0);
        write_byte(r, 1'b0);
        m_reg = r;
        i2c_start();
        rq.push_back({m_page, m_reg});
        write_byte({SLAVE_ADDR, 1'b1}, 1'b0);
        for (int i = 0; i < n; i++) begin
            read_byte(b);
            chk("rdata", {24'd0, b}, {24'd0, rmem[{m_page, m_reg}]});
            if (i < n - 1) begin
                m_reg = m_reg + 8'd1;
                rq.push_back({m_page, m_reg});
                write_bit(1'b0);
            end else write_bit(1'b1);
        end
        i2c_stop();
        qw();
    endtask

    // external read port: data appears after a rd_en_o request and stays stable
    initial forever begin
        @(negedge clk);
        if (rd_en) rd_data = rmem[rd_addr];
    end

    // monitor: every strobe must match the head of its expectation queue
    initial forever begin
        @(negedge clk);
        if (wr_en) begin
            if (wq.size() == 0) begin
                ncmp++; nerr++;
                $display("FAIL wr_strobe: got %h with nothing expected", {wr_addr, wr_data});
            end else chk("wr_strobe", {8'd0, wr_addr, wr_data}, {8'd0, wq.pop_front()});
        end
        if (rd_en) begin
            if (rq.size() == 0) begin
                ncmp++; nerr++;
                $display("FAIL rd_strobe: got %h with nothing expected", rd_addr);
            end else chk("rd_addr", {16'd0, rd_addr}, {16'd0, rq.pop_front()});
        end
    end

    initial begin
        #600000;
        nerr++;
        $display("FAIL timeout: simulation did not reach the end");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        logic [7:0] r;
        logic [6:0] a;
        int n;
        for (int i = 0; i < 65536; i++) rmem[i] = 8'($urandom);
        rmem[16'h0040] = 8'h5A;
        rmem[16'h0041] = 8'hA5;
        rmem[16'h0740] = 8'h12;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_oe", {31'd0, sda_oe}, 0);
        chk("rst_wr", {15'd0, wr_en, wr_addr}, 0);
        chk("rst_rd", {15'd0, rd_en, rd_addr}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rstn = 1'b1;
        qw();

        wr_txn(SLAVE_ADDR, 8'h01, 1, 24'h0B0000);
        wr_txn(SLAVE_ADDR, 8'h24, 1, 24'hD80000);

        i2c_start();
        chk("busy_start", {31'd0, busy}, 1);
        write_byte({7'h75, 1'b0}, 1'b1);
        write_byte(8'h10, 1'b1);
        write_byte(8'h55, 1'b1);
        chk("busy_ignore", {31'd0, busy}, 1);
        i2c_stop();
        repeat (6) @(posedge clk);
        chk("busy_stop", {31'd0, busy}, 0);

        wr_txn(7'h00, 8'h10, 1, 24'h550000);
        wr_txn(SLAVE_ADDR, 8'h01, 1, 24'h000000);
        wr_txn(SLAVE_ADDR, 8'hFE, 3, 24'h112233);
        rd_txn(8'h40, 2);

        i2c_start();
        write_byte({SLAVE_ADDR, 1'b0}, 1'b0);
        write_byte(8'h30, 1'b0);
        m_reg = 8'h30;
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop();
        repeat (6) @(posedge clk);
        chk("busy_midbyte", {31'd0, busy}, 0);
        wr_txn(SLAVE_ADDR, 8'h31, 2, 24'h6677_00);

        wr_txn(SLAVE_ADDR, 8'h01, 1, 24'h070000);
        i2c_start();
        write_byte({SLAVE_ADDR, 1'b0}, 1'b0);
        write_byte(8'h40, 1'b0);
        m_reg = 8'h40;
        i2c_start();
        rq.push_back({m_page, m_reg});
        write_byte({SLAVE_ADDR, 1'b1}, 1'b0);
        repeat (2) @(posedge clk);
        chk("oe_before_reset", {31'd0, sda_oe}, 1);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("oe_after_reset", {31'd0, sda_oe}, 0);
        chk("busy_after_reset", {31'd0, busy}, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (6) @(posedge clk);
        m_page = 8'h00;
        m_reg = 8'h00;
        rstn = 1'b1;
        qw();
        wr_txn(SLAVE_ADDR, 8'h24, 1, 24'h990000);

        for (int k = 0; k < 10; k++) begin
            r = ($urandom_range(0, 3) == 0) ? PAGE_REG : 8'($urandom);
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 2) == 0) rd_txn(r, n);
            else begin
                a = ($urandom_range(0, 3) == 0) ? (SLAVE_ADDR ^ 7'(1 << $urandom_range(0, 6))) : SLAVE_ADDR;
                wr_txn(a, r, n, 24'($urandom));
            end
        end

        qw(4);
        chk("wq_left", wq.size(), 0);
        chk("rq_left", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
